// File: rtl/alu_cond_resolver_pkg.sv
// Shared opcode, condition-code and flag-position definitions
// for the execute-stage branch condition resolver.
package alu_cond_resolver_pkg;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SLT = 3'd5;
  localparam logic [2:0] ALU_SRL = 3'd6;
  localparam logic [2:0] ALU_SLL = 3'd7;

  typedef enum logic [2:0] {
    COND_EQ = 3'd0,
    COND_NE = 3'd1,
    COND_LT = 3'd2,
    COND_GE = 3'd3,
    COND_LE = 3'd4,
    COND_GT = 3'd5,
    COND_VS = 3'd6,
    COND_AL = 3'd7
  } cond_e;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

endpackage

// File: rtl/alu_cond_resolver_cond_eval.sv
// Pure combinational evaluation of a branch condition
// against a {z,v,n} flag set.
module cond_eval
  import alu_cond_resolver_pkg::*;
(
  input  logic       i_z,
  input  logic       i_v,
  input  logic       i_n,
  input  logic [2:0] i_cond,
  output logic       o_taken
);

  logic w_lt;
  assign w_lt = i_n ^ i_v;

  always_comb begin
    o_taken = 1'b0;
    unique case (cond_e'(i_cond))
      COND_EQ: o_taken = i_z;
      COND_NE: o_taken = !i_z;
      COND_LT: o_taken = w_lt;
      COND_GE: o_taken = !w_lt;
      COND_LE: o_taken = i_z | w_lt;
      COND_GT: o_taken = !(i_z | w_lt);
      COND_VS: o_taken = i_v;
      COND_AL: o_taken = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_cond_resolver.sv
// Tracks in-flight flag writers, latches ALU flags and resolves
// conditional branches into a registered redirect PC.
module alu_cond_resolver
  import alu_cond_resolver_pkg::*;
#(
  parameter int MAX_PEND = 3,
  parameter bit BYPASS   = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_issue_flag,
  input  logic        i_alu_valid,
  input  logic [2:0]  i_alu_op,
  input  logic [15:0] i_alu_result,
  input  logic        i_alu_z,
  input  logic        i_alu_v,
  input  logic        i_alu_n,
  input  logic        i_br_valid,
  output logic        o_br_ready,
  input  logic [2:0]  i_br_cond,
  input  logic [15:0] i_br_target,
  input  logic [15:0] i_br_pc_next,
  output logic        o_res_valid,
  output logic        o_res_taken,
  output logic [15:0] o_res_pc,
  output logic [2:0]  o_flags,
  output logic        o_pend_err
);

  localparam int CW = $clog2(MAX_PEND + 1);

  logic [CW-1:0] r_pend;
  logic [2:0]    r_flags;
  logic          r_err;
  logic          r_res_valid;
  logic          r_res_taken;
  logic [15:0]   r_res_pc;

  logic       w_unused;
  logic [2:0] w_live;
  logic [2:0] w_eval;
  logic       w_empty;
  logic       w_one;
  logic       w_full;
  logic       w_inc;
  logic       w_dec;
  logic       w_accept;
  logic       w_taken;

  // opcode and result are carried on the bus but never inspected
  assign w_unused = ^{i_alu_op, i_alu_result};

  assign w_live  = {i_alu_z, i_alu_v, i_alu_n};
  assign w_empty = (r_pend == '0);
  assign w_one   = (r_pend == CW'(1));
  assign w_full  = (r_pend == CW'(MAX_PEND));
  assign w_inc   = i_issue_flag & !i_alu_valid;
  assign w_dec   = i_alu_valid & !i_issue_flag;

  assign o_br_ready = w_empty | (BYPASS & w_one & i_alu_valid);
  assign w_eval     = (w_one & i_alu_valid) ? w_live : r_flags;
  assign w_accept   = i_br_valid & o_br_ready;

  cond_eval u_cond (
    .i_z     (w_eval[FLAG_Z]),
    .i_v     (w_eval[FLAG_V]),
    .i_n     (w_eval[FLAG_N]),
    .i_cond  (i_br_cond),
    .o_taken (w_taken)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pend      <= '0;
      r_flags     <= 3'b000;
      r_err       <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_taken <= 1'b0;
      r_res_pc    <= 16'h0000;
    end else begin
      if (i_alu_valid) r_flags <= w_live;
      if (w_inc && !w_full) r_pend <= r_pend + CW'(1);
      else if (w_dec && !w_empty) r_pend <= r_pend - CW'(1);
      if ((w_inc && w_full) || (w_dec && w_empty)) r_err <= 1'b1;
      r_res_valid <= w_accept;
      if (w_accept) begin
        r_res_taken <= w_taken;
        r_res_pc    <= w_taken ? i_br_target : i_br_pc_next;
      end
    end
  end

  assign o_res_valid = r_res_valid;
  assign o_res_taken = r_res_taken;
  assign o_res_pc    = r_res_pc;
  assign o_flags     = r_flags;
  assign o_pend_err  = r_err;

endmodule

// File: tb/tb_alu_cond_resolver.sv
// Directed plus random checks of the resolver, with and without
// bypass, against an in-bench behavioural model.
module tb_alu_cond_resolver;

  localparam int MAXP = 3;

  logic        clk = 1'b0;
  logic        rst, iss, av, z, v, n, bv;
  logic [2:0]  op, cc;
  logic [15:0] res, tg, pn;

  logic        rdy1, rv1, rt1, err1;
  logic        rdy0, rv0, rt0, err0;
  logic [15:0] pc1, pc0;
  logic [2:0]  fl1, fl0;

  int n_chk = 0;
  int n_fail = 0;

  int         m_pend [2];
  logic [2:0] m_fl   [2];
  bit         m_err  [2];
  bit         m_rv   [2];
  bit         m_rt   [2];
  logic [15:0] m_pc  [2];

  always #5 clk = ~clk;

  alu_cond_resolver #(.MAX_PEND(MAXP), .BYPASS(1'b1)) u_b1 (
    .i_clk(clk), .i_rst(rst), .i_issue_flag(iss), .i_alu_valid(av),
    .i_alu_op(op), .i_alu_result(res),
    .i_alu_z(z), .i_alu_v(v), .i_alu_n(n),
    .i_br_valid(bv), .o_br_ready(rdy1), .i_br_cond(cc),
    .i_br_target(tg), .i_br_pc_next(pn),
    .o_res_valid(rv1), .o_res_taken(rt1), .o_res_pc(pc1),
    .o_flags(fl1), .o_pend_err(err1)
  );

  alu_cond_resolver #(.MAX_PEND(MAXP), .BYPASS(1'b0)) u_b0 (
    .i_clk(clk), .i_rst(rst), .i_issue_flag(iss), .i_alu_valid(av),
    .i_alu_op(op), .i_alu_result(res),
    .i_alu_z(z), .i_alu_v(v), .i_alu_n(n),
    .i_br_valid(bv), .o_br_ready(rdy0), .i_br_cond(cc),
    .i_br_target(tg), .i_br_pc_next(pn),
    .o_res_valid(rv0), .o_res_taken(rt0), .o_res_pc(pc0),
    .o_flags(fl0), .o_pend_err(err0)
  );

  function automatic bit cond_ok(input logic [2:0] c, input logic [2:0] f);
    bit fz, fv, fn, less;
    fz = f[2]; fv = f[1]; fn = f[0];
    less = (fn != fv);
    case (c)
      3'd0: return fz;
      3'd1: return !fz;
      3'd2: return less;
      3'd3: return !less;
      3'd4: return fz || less;
      3'd5: return !(fz || less);
      3'd6: return fv;
      default: return 1'b1;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit i_, input bit a,
                      input logic [2:0] f, input bit b,
                      input logic [2:0] c, input logic [15:0] t,
                      input logic [15:0] p);
    bit rdy_e, acc;
    logic [2:0] src;
    int np [2];
    logic [2:0] nf [2];
    bit ne [2], nv [2], nt [2];
    logic [15:0] npc [2];
    rst = r; iss = i_; av = a;
    z = f[2]; v = f[1]; n = f[0];
    op = 3'($urandom); res = 16'($urandom);
    bv = b; cc = c; tg = t; pn = p;
    #1;
    for (int k = 0; k < 2; k++) begin
      rdy_e = (m_pend[k] == 0) || (k == 1 && m_pend[k] == 1 && a);
      if (!r) chk(k ? "ready_b1" : "ready_b0",
                  {15'd0, k ? rdy1 : rdy0}, {15'd0, rdy_e});
      src = (m_pend[k] == 1 && a) ? f : m_fl[k];
      acc = b && rdy_e;
      np[k] = m_pend[k]; nf[k] = a ? f : m_fl[k]; ne[k] = m_err[k];
      nv[k] = acc; nt[k] = m_rt[k]; npc[k] = m_pc[k];
      if (acc) begin
        nt[k] = cond_ok(c, src);
        npc[k] = nt[k] ? t : p;
      end
      if (i_ && !a) begin
        if (m_pend[k] == MAXP) ne[k] = 1'b1; else np[k]++;
      end
      if (a && !i_) begin
        if (m_pend[k] == 0) ne[k] = 1'b1; else np[k]--;
      end
      if (r) begin
        np[k] = 0; nf[k] = 3'b000; ne[k] = 0; nv[k] = 0;
        nt[k] = 0; npc[k] = 16'h0000;
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = np[k]; m_fl[k] = nf[k]; m_err[k] = ne[k];
      m_rv[k] = nv[k]; m_rt[k] = nt[k]; m_pc[k] = npc[k];
    end
    chk("res_valid_b1", {15'd0, rv1}, {15'd0, m_rv[1]});
    chk("res_valid_b0", {15'd0, rv0}, {15'd0, m_rv[0]});
    chk("res_taken_b1", {15'd0, rt1}, {15'd0, m_rt[1]});
    chk("res_taken_b0", {15'd0, rt0}, {15'd0, m_rt[0]});
    chk("res_pc_b1", pc1, m_pc[1]);
    chk("res_pc_b0", pc0, m_pc[0]);
    chk("flags_b1", {13'd0, fl1}, {13'd0, m_fl[1]});
    chk("flags_b0", {13'd0, fl0}, {13'd0, m_fl[0]});
    chk("pend_err_b1", {15'd0, err1}, {15'd0, m_err[1]});
    chk("pend_err_b0", {15'd0, err0}, {15'd0, m_err[0]});
  endtask

  task automatic idle();
    step(0, 0, 0, 3'b000, 0, 3'd0, 16'h0, 16'h0);
  endtask

  initial begin
    logic [2:0] seq_cc [6];
    bit         seq_tk [6];
    bit         ri, ra, rb, rr;
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = 0; m_fl[k] = 0; m_err[k] = 0;
      m_rv[k] = 0; m_rt[k] = 0; m_pc[k] = 0;
    end

    // reset state
    step(1, 0, 0, 3'b000, 0, 3'd0, 16'h0, 16'h0);
    step(1, 1, 1, 3'b111, 1, 3'd7, 16'hffff, 16'hffff);
    chk("rst_res_pc", pc1, 16'h0000);
    idle();

    // BEQ waits on a pending writer, resolves via bypass / after retire
    step(0, 1, 0, 3'b000, 0, 3'd0, 16'h0040, 16'h0044);
    step(0, 0, 0, 3'b000, 1, 3'd0, 16'h0040, 16'h0044);
    step(0, 0, 1, 3'b100, 1, 3'd0, 16'h0040, 16'h0044);
    chk("beq_pc_b1", pc1, 16'h0040);
    step(0, 0, 0, 3'b000, 1, 3'd0, 16'h0040, 16'h0044);
    chk("beq_pc_b0", pc0, 16'h0040);
    idle();

    // BLT on live n=1 v=0 at pend==1
    step(0, 1, 0, 3'b000, 0, 3'd0, 16'h0, 16'h0);
    step(0, 0, 1, 3'b001, 1, 3'd2, 16'h0100, 16'h0104);
    chk("blt_pc_b1", pc1, 16'h0100);
    step(0, 0, 0, 3'b000, 1, 3'd2, 16'h0100, 16'h0104);
    chk("blt_pc_b0", pc0, 16'h0100);
    idle();

    // n=1 v=1 z=0, then six back-to-back branches
    step(0, 1, 0, 3'b000, 0, 3'd0, 16'h0, 16'h0);
    step(0, 0, 1, 3'b011, 0, 3'd0, 16'h0, 16'h0);
    seq_cc = '{3'd3, 3'd2, 3'd5, 3'd4, 3'd6, 3'd7};
    seq_tk = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 3'b000, 1, seq_cc[i], 16'h0200 + 16'(i), 16'h0300);
      chk("seq_valid", {15'd0, rv1}, 16'd1);
      chk("seq_taken", {15'd0, rt1}, {15'd0, seq_tk[i]});
    end
    idle();

    // simultaneous issue/retire at pend==1, then overflow
    step(0, 1, 0, 3'b000, 0, 3'd0, 16'h0, 16'h0);
    step(0, 1, 1, 3'b110, 1, 3'd6, 16'h0500, 16'h0504);
    step(0, 0, 1, 3'b000, 0, 3'd0, 16'h0, 16'h0);
    for (int i = 0; i < 4; i++)
      step(0, 1, 0, 3'b000, 0, 3'd0, 16'h0, 16'h0);
    chk("ovf_err", {15'd0, err1}, 16'd1);
    idle();
    idle();

    // accept then reset; underflow retire after reset
    step(1, 0, 0, 3'b000, 0, 3'd0, 16'h0, 16'h0);
    step(0, 0, 0, 3'b000, 1, 3'd7, 16'h0600, 16'h0604);
    step(1, 0, 0, 3'b000, 0, 3'd0, 16'h0, 16'h0);
    chk("rst_kill_valid", {15'd0, rv1}, 16'd0);
    step(0, 0, 1, 3'b101, 0, 3'd0, 16'h0, 16'h0);
    chk("unf_err", {15'd0, err1}, 16'd1);
    chk("unf_flags", {13'd0, fl1}, 16'd5);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rr = ($urandom_range(0, 39) == 0);
      ri = ($urandom_range(0, 2) == 0);
      ra = ($urandom_range(0, 2) == 0);
      rb = ($urandom_range(0, 1) == 0);
      step(rr, ri, ra, 3'($urandom), rb, 3'($urandom),
           16'($urandom), 16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
